// File: rtl/fifo_arbiter_if.sv
// Handshake bundle between the fifo_arbiter, its two writers, its reader and the shared fifo.
// The arbiter uses the slave view; requesters and the fifo together form the master view.
interface fifo_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 256
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             i_wr0_req;
  logic [WIDTH-1:0] i_wr0_data;
  logic             o_wr0_ack;
  logic             i_wr1_req;
  logic [WIDTH-1:0] i_wr1_data;
  logic             o_wr1_ack;
  logic             i_rd_req;
  logic             o_rd_ack;
  logic [WIDTH-1:0] o_rd_data;
  logic             o_fifo_en;
  logic             o_fifo_set;
  logic             o_fifo_get;
  logic [WIDTH-1:0] o_fifo_data;
  logic             i_fifo_set;
  logic             i_fifo_get;
  logic [WIDTH-1:0] i_fifo_data;
  logic [CW-1:0]    o_count;
  logic             o_full;
  logic             o_empty;
  logic             o_busy;
  logic             o_err;

  modport slave (
    input  i_wr0_req, i_wr0_data, i_wr1_req, i_wr1_data, i_rd_req,
           i_fifo_set, i_fifo_get, i_fifo_data,
    output o_wr0_ack, o_wr1_ack, o_rd_ack, o_rd_data,
           o_fifo_en, o_fifo_set, o_fifo_get, o_fifo_data,
           o_count, o_full, o_empty, o_busy, o_err
  );

  modport master (
    output i_wr0_req, i_wr0_data, i_wr1_req, i_wr1_data, i_rd_req,
           i_fifo_set, i_fifo_get, i_fifo_data,
    input  o_wr0_ack, o_wr1_ack, o_rd_ack, o_rd_data,
           o_fifo_en, o_fifo_set, o_fifo_get, o_fifo_data,
           o_count, o_full, o_empty, o_busy, o_err
  );
endinterface

// File: rtl/fifo_arbiter.sv
// Round-robin arbiter sharing one pulse-handshake fifo between two writers and one reader;
// tracks occupancy so the fifo is never written when full or read when empty.
module fifo_arbiter #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 256,
  parameter int TIMEOUT = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  fifo_arbiter_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] COUNT_MAX = CW'(DEPTH);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, WAIT, GAP} state_t;
  typedef enum logic [1:0] {SEL_WR0, SEL_WR1, SEL_RD} sel_t;

  state_t           state_q, state_d;
  sel_t             last_q, last_d;
  sel_t             gnt_q, gnt_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] fifo_data_q, fifo_data_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             fifo_set_q, fifo_set_d;
  logic             fifo_get_q, fifo_get_d;
  logic             wr0_ack_q, wr0_ack_d;
  logic             wr1_ack_q, wr1_ack_d;
  logic             rd_ack_q, rd_ack_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic             fifo_en_q;

  logic elig_wr0, elig_wr1, elig_rd;
  logic pick_valid, done;
  sel_t pick;

  assign elig_wr0 = bus.i_wr0_req && !full_q;
  assign elig_wr1 = bus.i_wr1_req && !full_q;
  assign elig_rd  = bus.i_rd_req  && !empty_q;

  // Search starts just after the last granted requester in the ring wr0 -> wr1 -> rd.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    pick_valid = 1'b1;
    pick       = SEL_WR0;
    unique case (last_q)
      SEL_WR0: if (elig_wr1) pick = SEL_WR1; else if (elig_rd)  pick = SEL_RD;
               else if (elig_wr0) pick = SEL_WR0; else pick_valid = 1'b0;
      SEL_WR1: if (elig_rd)  pick = SEL_RD;  else if (elig_wr0) pick = SEL_WR0;
               else if (elig_wr1) pick = SEL_WR1; else pick_valid = 1'b0;
      default: if (elig_wr0) pick = SEL_WR0; else if (elig_wr1) pick = SEL_WR1;
               else if (elig_rd)  pick = SEL_RD;  else pick_valid = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    gnt_d       = gnt_q;
    tmo_d       = tmo_q;
    count_d     = count_q;
    fifo_data_d = fifo_data_q;
    rd_data_d   = rd_data_q;
    err_d       = err_q;
    fifo_set_d  = 1'b0;
    fifo_get_d  = 1'b0;
    wr0_ack_d   = 1'b0;
    wr1_ack_d   = 1'b0;
    rd_ack_d    = 1'b0;
    done        = (gnt_q == SEL_RD) ? bus.i_fifo_get : bus.i_fifo_set;

    unique case (state_q)
      IDLE: if (pick_valid) begin
        gnt_d   = pick;
        last_d  = pick;
        tmo_d   = '0;
        state_d = WAIT;
        if (pick == SEL_RD) begin
          fifo_get_d = 1'b1;
        end else begin
          fifo_set_d  = 1'b1;
          fifo_data_d = (pick == SEL_WR0) ? bus.i_wr0_data : bus.i_wr1_data;
        end
      end
      WAIT: if (done || tmo_q == TMO_LAST) begin
        state_d   = GAP;
        wr0_ack_d = (gnt_q == SEL_WR0);
        wr1_ack_d = (gnt_q == SEL_WR1);
        rd_ack_d  = (gnt_q == SEL_RD);
        if (!done) begin
          err_d = 1'b1;  // timed out: ack anyway, occupancy untouched
        end else if (gnt_q == SEL_RD) begin
          rd_data_d = bus.i_fifo_data;
          if (count_q != '0) count_d = count_q - CW'(1);
        end else if (count_q != COUNT_MAX) begin
          count_d = count_q + CW'(1);
        end
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
      default: state_d = IDLE;
    endcase

    full_d  = (count_d == COUNT_MAX);
    empty_d = (count_d == '0);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (i_rst) begin
      state_q     <= IDLE;
      last_q      <= SEL_RD;
      gnt_q       <= SEL_WR0;
      tmo_q       <= '0;
      count_q     <= '0;
      fifo_data_q <= '0;
      rd_data_q   <= '0;
      fifo_set_q  <= 1'b0;
      fifo_get_q  <= 1'b0;
      wr0_ack_q   <= 1'b0;
      wr1_ack_q   <= 1'b0;
      rd_ack_q    <= 1'b0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      fifo_en_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      gnt_q       <= gnt_d;
      tmo_q       <= tmo_d;
      count_q     <= count_d;
      fifo_data_q <= fifo_data_d;
      rd_data_q   <= rd_data_d;
      fifo_set_q  <= fifo_set_d;
      fifo_get_q  <= fifo_get_d;
      wr0_ack_q   <= wr0_ack_d;
      wr1_ack_q   <= wr1_ack_d;
      rd_ack_q    <= rd_ack_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      fifo_en_q   <= 1'b1;
    end
  end

  assign bus.o_wr0_ack   = wr0_ack_q;
  assign bus.o_wr1_ack   = wr1_ack_q;
  assign bus.o_rd_ack    = rd_ack_q;
  assign bus.o_rd_data   = rd_data_q;
  assign bus.o_fifo_en   = fifo_en_q;
  assign bus.o_fifo_set  = fifo_set_q;
  assign bus.o_fifo_get  = fifo_get_q;
  assign bus.o_fifo_data = fifo_data_q;
  assign bus.o_count     = count_q;
  assign bus.o_full      = full_q;
  assign bus.o_empty     = empty_q;
  assign bus.o_busy      = busy_q;
  assign bus.o_err       = err_q;
endmodule

// File: tb/tb_fifo_arbiter.sv
// Directed bench for fifo_arbiter (DEPTH=4) with a small pulse-handshake fifo model
// whose done pulses can be switched off to exercise the timeout.
module tb_fifo_arbiter;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stub_off = 1'b0;
  int   checks = 0;
  int   errors = 0;

  fifo_arbiter_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  fifo_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(4)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Fifo model: done pulse one cycle after each set/get request.
  logic [WIDTH-1:0] mem [DEPTH];
  logic [1:0]       wp, rp;
  always @(posedge clk) begin
    if (rst) begin
      bus.i_fifo_set  <= 1'b0;
      bus.i_fifo_get  <= 1'b0;
      bus.i_fifo_data <= '0;
      wp <= '0;
      rp <= '0;
    end else begin
      bus.i_fifo_set <= bus.o_fifo_set && !stub_off;
      bus.i_fifo_get <= bus.o_fifo_get && !stub_off;
      if (bus.o_fifo_set && !stub_off) begin
        mem[wp] <= bus.o_fifo_data;
        wp      <= wp + 2'd1;
      end
      if (bus.o_fifo_get && !stub_off) begin
        bus.i_fifo_data <= mem[rp];
        rp              <= rp + 2'd1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] ack_vec();
    return {bus.o_rd_ack, bus.o_wr1_ack, bus.o_wr0_ack};
  endfunction

  task automatic set_req(input int which, input logic val);
    case (which)
      0:       bus.i_wr0_req = val;
      1:       bus.i_wr1_req = val;
      default: bus.i_rd_req  = val;
    endcase
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Waits up to max_cycles for any ack; an expired bound is a failed check.
  task automatic wait_any_ack(input int max_cycles, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < max_cycles && !seen; i++) begin
      tick();
      seen = (ack_vec() != 3'b000);
    end
    check(tag, 32'(seen), 32'(1));
  endtask

  // Single write from IDLE with exact handshake timing; returns with the arbiter back in IDLE.
  task automatic wr_op(input int which, input logic [7:0] data, input int exp_count);
    if (which == 0) bus.i_wr0_data = data; else bus.i_wr1_data = data;
    set_req(which, 1'b1);
    tick();
    check("wr_set_pulse", 32'(bus.o_fifo_set), 32'(1));
    check("wr_fifo_data", 32'(bus.o_fifo_data), 32'(data));
    tick();
    check("wr_set_drop", 32'(bus.o_fifo_set), 32'(0));
    check("wr_busy", 32'(bus.o_busy), 32'(1));
    tick();
    check("wr_ack", 32'(ack_vec()), 32'(3'b001 << which));
    check("wr_count", 32'(bus.o_count), 32'(exp_count));
    set_req(which, 1'b0);
    tick();
    check("wr_ack_drop", 32'(ack_vec()), 32'(0));
  endtask

  initial begin
    int   exp_order [4];
    logic bad;
    exp_order = '{0, 1, 2, 0};
    bus.i_wr0_req  = 1'b0;
    bus.i_wr1_req  = 1'b0;
    bus.i_rd_req   = 1'b0;
    bus.i_wr0_data = '0;
    bus.i_wr1_data = '0;

    // Reset values
    tick();
    tick();
    check("rst_empty", 32'(bus.o_empty), 32'(1));
    check("rst_count", 32'(bus.o_count), 32'(0));
    check("rst_fifo_en", 32'(bus.o_fifo_en), 32'(0));
    check("rst_busy_err", 32'({bus.o_busy, bus.o_err, bus.o_full}), 32'(0));
    rst = 1'b0;
    tick();
    check("fifo_en_after_rst", 32'(bus.o_fifo_en), 32'(1));

    // Single write of 0xA5
    wr_op(0, 8'hA5, 1);
    check("a5_empty", 32'(bus.o_empty), 32'(0));

    // All three held from reset: wr0, wr1, rd, wr0
    bus.i_wr0_data = 8'h11;
    bus.i_wr1_data = 8'h22;
    bus.i_wr0_req  = 1'b1;
    bus.i_wr1_req  = 1'b1;
    bus.i_rd_req   = 1'b1;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      wait_any_ack(8, "rr_ack_seen");
      check("rr_grant", 32'(ack_vec()), 32'(3'b001 << exp_order[k]));
      check("rr_count", 32'(bus.o_count), 32'((k == 2) ? 1 : (k == 0) ? 1 : 2));
      if (exp_order[k] == 2) check("rr_rd_data", 32'(bus.o_rd_data), 32'(8'h11));
      set_req(exp_order[k], 1'b0);
      tick();
      tick();
      if (k < 3) set_req(exp_order[k], 1'b1);
    end
    bus.i_wr0_req = 1'b0;
    bus.i_wr1_req = 1'b0;
    bus.i_rd_req  = 1'b0;

    // Read on empty is never granted; a write of 0x3C then unblocks it
    do_reset();
    bus.i_rd_req = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      bad = bad | bus.o_fifo_get | bus.o_rd_ack | bus.o_busy;
    end
    check("rd_empty_blocked", 32'(bad), 32'(0));
    wr_op(0, 8'h3C, 1);
    wait_any_ack(6, "rd_after_wr_seen");
    check("rd_after_wr_ack", 32'(ack_vec()), 32'(3'b100));
    check("rd_after_wr_data", 32'(bus.o_rd_data), 32'(8'h3C));
    check("rd_after_wr_empty", 32'({bus.o_count, bus.o_empty}), 32'(1));
    bus.i_rd_req = 1'b0;
    tick();

    // Fill to DEPTH, fifth write blocked until a read: 4 -> 3 -> 4
    for (int i = 0; i < 4; i++) wr_op(0, 8'(i + 1), i + 1);
    check("full_set", 32'(bus.o_full), 32'(1));
    bus.i_wr1_data = 8'h55;
    bus.i_wr1_req  = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      bad = bad | bus.o_fifo_set | bus.o_wr1_ack;
    end
    check("full_wr_blocked", 32'(bad), 32'(0));
    check("full_count", 32'(bus.o_count), 32'(4));
    bus.i_rd_req = 1'b1;
    wait_any_ack(6, "full_rd_seen");
    check("full_rd_ack", 32'(ack_vec()), 32'(3'b100));
    check("full_rd_count", 32'(bus.o_count), 32'(3));
    check("full_rd_data", 32'(bus.o_rd_data), 32'(8'h01));
    check("full_cleared", 32'(bus.o_full), 32'(0));
    bus.i_rd_req = 1'b0;
    wait_any_ack(8, "full_wr1_seen");
    check("full_wr1_ack", 32'(ack_vec()), 32'(3'b010));
    check("refill_count", 32'({bus.o_count, bus.o_full}), 32'({3'd4, 1'b1}));
    bus.i_wr1_req = 1'b0;
    tick();

    // Done pulse stubbed off: timeout at the fourth WAIT edge
    do_reset();
    stub_off = 1'b1;
    bus.i_wr0_data = 8'h77;
    bus.i_wr0_req  = 1'b1;
    tick();
    check("tmo_set_pulse", 32'(bus.o_fifo_set), 32'(1));
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      bad = bad | bus.o_wr0_ack | bus.o_err;
    end
    check("tmo_early_quiet", 32'(bad), 32'(0));
    tick();
    check("tmo_ack", 32'(bus.o_wr0_ack), 32'(1));
    check("tmo_err", 32'(bus.o_err), 32'(1));
    check("tmo_count", 32'(bus.o_count), 32'(0));
    bus.i_wr0_req = 1'b0;
    stub_off = 1'b0;
    tick();
    check("tmo_err_sticky", 32'({bus.o_err, bus.o_wr0_ack}), 32'(2'b10));

    // Reset during WAIT aborts the write
    do_reset();
    check("rst_clears_err", 32'(bus.o_err), 32'(0));
    bus.i_wr0_data = 8'h99;
    bus.i_wr0_req  = 1'b1;
    tick();
    check("abort_busy", 32'(bus.o_busy), 32'(1));
    rst = 1'b1;
    bus.i_wr0_req = 1'b0;
    tick();
    check("abort_outputs", 32'({bus.o_busy, bus.o_wr0_ack, bus.o_fifo_set, bus.o_fifo_en}), 32'(0));
    check("abort_count", 32'({bus.o_count, bus.o_empty}), 32'(1));
    rst = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      bad = bad | (ack_vec() != 3'b000);
    end
    check("abort_no_ack", 32'(bad), 32'(0));
    wr_op(1, 8'h42, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
